// File: rtl/bp_me_pkg.sv
// Shared BedRock message definitions and stream-decode helpers for the memory-engine pumps.
package bp_me_pkg;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_msg_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    localparam int bedrock_msg_type_width = 4;
    localparam int bedrock_subop_width    = 4;
    localparam int bedrock_size_width     = 3;
    localparam int bedrock_mask_width     = 1 << bedrock_msg_type_width;

    // Header layout, LSB first: msg_type, subop, addr, size, payload.
    function automatic int bedrock_header_width(input int paddr_width, input int payload_width);
        return payload_width + bedrock_size_width + paddr_width
             + bedrock_subop_width + bedrock_msg_type_width;
    endfunction

    // Stream masks are built by OR-ing one bit per message type.
    function automatic logic [bedrock_mask_width-1:0] bedrock_mask(input bp_bedrock_msg_type_e msg_type);
        return bedrock_mask_width'(1) << msg_type;
    endfunction

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Number of stream beats minus one for a message of 2^size bytes.
    function automatic int unsigned stream_size(input logic [2:0] size, input int unsigned stream_bytes);
        int unsigned beats;
        beats = (32'd1 << size) / stream_bytes;
        return (beats > 1) ? beats - 1 : 0;
    endfunction

endpackage

// File: rtl/bp_me_stream_wrap_counter.sv
// Beat counter producing a block-wrapped word index plus first/last flags for one message.
module bp_me_stream_wrap_counter
    import bp_me_pkg::*;
#(
    parameter int cnt_w = 3
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             en_i,
    input  logic [cnt_w-1:0] size_i,
    input  logic [cnt_w-1:0] first_cnt_i,
    output logic [cnt_w-1:0] wrap_o,
    output logic             first_o,
    output logic             last_o
);

    logic             busy_r;
    logic [cnt_w-1:0] cnt_r;
    logic [cnt_w-1:0] sum;

    // Bits above the message size keep the critical word's position; bits inside it wrap.
    assign sum     = first_cnt_i + cnt_r;
    assign wrap_o  = (first_cnt_i & ~size_i) | (sum & size_i);
    assign last_o  = (cnt_r == size_i);
    assign first_o = ~busy_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_r <= 1'b0;
            cnt_r  <= '0;
        end else if (en_i) begin
            if (last_o) begin
                busy_r <= 1'b0;
                cnt_r  <= '0;
            end else begin
                busy_r <= 1'b1;
                cnt_r  <= cnt_r + cnt_w'(1);
            end
        end
    end

endmodule

// File: rtl/bp_me_stream_pump_in.sv
// Receive-side stream pump: turns incoming BedRock stream beats into per-beat FSM transactions.
module bp_me_stream_pump_in
    import bp_me_pkg::*;
#(
    parameter int paddr_width_p       = 40,
    parameter int stream_data_width_p = 64,
    parameter int block_width_p       = 512,
    parameter int payload_width_p     = 16,
    parameter logic [bedrock_mask_width-1:0] msg_stream_mask_p = '0,
    parameter logic [bedrock_mask_width-1:0] fsm_stream_mask_p = msg_stream_mask_p,
    localparam int header_width = bedrock_header_width(paddr_width_p, payload_width_p),
    localparam int stream_bytes = stream_data_width_p / 8,
    localparam int stream_words = block_width_p / stream_data_width_p,
    localparam int cnt_w        = safe_clog2(stream_words),
    localparam int offset_w     = safe_clog2(stream_bytes)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [header_width-1:0]        msg_header_i,
    input  logic [stream_data_width_p-1:0] msg_data_i,
    input  logic                           msg_v_i,
    input  logic                           msg_last_i,
    output logic                           msg_ready_and_o,
    output logic [header_width-1:0]        fsm_header_o,
    output logic [paddr_width_p-1:0]       fsm_addr_o,
    output logic [stream_data_width_p-1:0] fsm_data_o,
    output logic                           fsm_v_o,
    input  logic                           fsm_ready_and_i,
    output logic [cnt_w-1:0]               fsm_cnt_o,
    output logic                           fsm_new_o,
    output logic                           fsm_last_o
);

    localparam int addr_lsb     = bedrock_msg_type_width + bedrock_subop_width;
    localparam int size_lsb     = addr_lsb + paddr_width_p;
    localparam int block_offset = offset_w + cnt_w;

    if ((block_width_p % stream_data_width_p != 0) || (block_width_p < stream_data_width_p)) begin : g_bad_params
        $error("block_width_p must be a non-zero multiple of stream_data_width_p");
    end

    logic [header_width-1:0]        hdr_r;
    logic [header_width-1:0]        hdr;
    logic [3:0]                     hdr_type;
    logic [paddr_width_p-1:0]       hdr_addr;
    logic [2:0]                     hdr_size;
    logic [cnt_w-1:0]               stream_size_w;
    logic [cnt_w-1:0]               size;
    logic [cnt_w-1:0]               first_cnt;
    logic [cnt_w-1:0]               wrap;
    logic [paddr_width_p-1:0]       stream_addr;
    logic nz, fsm_stream, msg_stream, one_to_n, n_to_one;
    logic first, last, en;
    logic fsm_v_int, msg_ready_int, exp_msg_last;

    // The live header is used on the first beat so there is no bubble between messages.
    assign hdr      = first ? msg_header_i : hdr_r;
    assign hdr_type = hdr[0 +: bedrock_msg_type_width];
    assign hdr_addr = hdr[addr_lsb +: paddr_width_p];
    assign hdr_size = hdr[size_lsb +: bedrock_size_width];

    assign stream_size_w = cnt_w'(stream_size(hdr_size, stream_bytes));
    assign nz            = (stream_size_w != '0);
    assign fsm_stream    = fsm_stream_mask_p[hdr_type] & nz;
    assign msg_stream    = msg_stream_mask_p[hdr_type] & nz;
    assign one_to_n      = fsm_stream & ~msg_stream;
    assign n_to_one      = msg_stream & ~fsm_stream;
    assign size          = (fsm_stream | msg_stream) ? stream_size_w : '0;
    assign first_cnt     = hdr_addr[offset_w +: cnt_w];

    always_comb begin
        fsm_v_int     = msg_v_i;
        msg_ready_int = fsm_ready_and_i;
        en            = msg_v_i & fsm_ready_and_i;
        if (one_to_n) begin
            msg_ready_int = fsm_ready_and_i & last;
            en            = fsm_v_int & fsm_ready_and_i;
        end else if (n_to_one) begin
            // Non-final msg beats are consumed without an FSM transaction.
            fsm_v_int     = msg_v_i & last;
            msg_ready_int = ~last | fsm_ready_and_i;
            en            = msg_v_i & msg_ready_int;
        end
    end

    bp_me_stream_wrap_counter #(
        .cnt_w(cnt_w)
    ) counter (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .en_i       (en),
        .size_i     (size),
        .first_cnt_i(first_cnt),
        .wrap_o     (wrap),
        .first_o    (first),
        .last_o     (last)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hdr_r <= '0;
        end else if (en && first) begin
            hdr_r <= msg_header_i;
        end
    end

    if (stream_words > 1) begin : g_wrap_addr
        assign stream_addr = {hdr_addr[paddr_width_p-1:block_offset], wrap, hdr_addr[offset_w-1:0]};
    end else begin : g_flat_addr
        assign stream_addr = hdr_addr;
    end

    assign msg_ready_and_o = msg_ready_int & reset_n_i;
    assign fsm_v_o         = fsm_v_int & reset_n_i;
    assign fsm_header_o    = hdr;
    assign fsm_addr_o      = n_to_one ? hdr_addr : stream_addr;
    assign fsm_data_o      = msg_data_i;
    assign fsm_cnt_o       = wrap;
    assign fsm_new_o       = first;
    assign fsm_last_o      = last;

    assign exp_msg_last = msg_stream ? last : 1'b1;

    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (msg_v_i && msg_ready_int && !one_to_n) |-> (msg_last_i == exp_msg_last));

endmodule
